// File: rtl/vga_scaled_display_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scaled_display_if
// Brief    : Framebuffer read bus between the VGA display and pixel memory.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_scaled_display_if #(
    parameter int PIX_BITS = 2,
    parameter int ADDR_W   = 17
);
    logic                fb_rd_en;
    logic [ADDR_W-1:0]   fb_rd_addr;
    logic [PIX_BITS-1:0] fb_rd_data;

    modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
    modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface
`default_nettype wire

// File: rtl/vga_scaled_display.sv
`default_nettype none
// ============================================================================
// Module   : vga_scaled_display
// Brief    : VGA timing, pixel clock-enable, power-of-two framebuffer upscale,
//            palette lookup and frame-synchronous mode select.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scaled_display #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 1,
    parameter int PIX_BITS    = 2,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_W      = 17
) (
    input  wire                    clk,
    input  wire                    reset,
    input  wire [1:0]              mode,
    input  wire                    pal_we,
    input  wire [PIX_BITS-1:0]     pal_addr,
    input  wire [11:0]             pal_data,
    vga_scaled_display_if.master   fb,
    output logic                   hSync,
    output logic                   vSync,
    output logic [3:0]             VGA_R,
    output logic [3:0]             VGA_G,
    output logic [3:0]             VGA_B,
    output logic                   active_out,
    output logic                   frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int NPAL    = 1 << PIX_BITS;

    localparam logic [DW-1:0]     c_div_last   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]     c_h_last     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     c_h_act      = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     c_hs_beg     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     c_hs_end     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     c_v_last     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     c_v_act      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     c_v_act_last = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]     c_vs_beg     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     c_vs_end     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]     c_row_mask   = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] c_fb_w       = ADDR_W'(FB_W);
    localparam logic [BW-1:0]     c_bar_last   = BW'(BAR_W - 1);

    generate
        if (RD_LATENCY >= CLK_DIV) begin : g_bad_rd_latency
            $error("RD_LATENCY must be smaller than CLK_DIV");
        end
    endgenerate

    logic [DW-1:0]     r_div;
    logic [HW-1:0]     r_hcount;
    logic [VW-1:0]     r_vcount;
    logic [ADDR_W-1:0] r_row_base;
    logic [BW-1:0]     r_bar_px;
    logic [2:0]        r_bar_idx;
    logic              r_s1_vis, r_s1_hs, r_s1_vs;
    logic [2:0]        r_s1_bar;
    logic [1:0]        r_mode;
    logic [11:0]       r_pal [NPAL];

    logic              w_pix_ce, w_h_last, w_v_last, w_visible;
    logic              w_hs_n, w_vs_n, w_frame_tick;
    logic [ADDR_W-1:0] w_addr;
    logic [11:0]       w_colour;

    assign w_pix_ce     = (r_div == c_div_last);
    assign w_h_last     = (r_hcount == c_h_last);
    assign w_v_last     = (r_vcount == c_v_last);
    assign w_visible    = (r_hcount < c_h_act) && (r_vcount < c_v_act);
    assign w_hs_n       = !((r_hcount >= c_hs_beg) && (r_hcount < c_hs_end));
    assign w_vs_n       = !((r_vcount >= c_vs_beg) && (r_vcount < c_vs_end));
    assign w_frame_tick = w_pix_ce && w_h_last && (r_vcount == c_v_act_last);
    assign w_addr       = r_row_base + ADDR_W'(r_hcount >> SCALE_SHIFT);

    // Pixel divider and raster counters; row_base steps once per group of
    // 2^SCALE_SHIFT visible lines so the address needs no multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_hcount   <= '0;
            r_vcount   <= '0;
            r_row_base <= '0;
            r_bar_px   <= '0;
            r_bar_idx  <= '0;
        end else begin
            r_div <= r_div + 1'b1;
            if (w_pix_ce) begin
                if (w_h_last) begin
                    r_hcount  <= '0;
                    r_bar_px  <= '0;
                    r_bar_idx <= '0;
                    if (w_v_last) begin
                        r_vcount   <= '0;
                        r_row_base <= '0;
                    end else begin
                        r_vcount <= r_vcount + 1'b1;
                        if ((r_vcount < c_v_act) && ((r_vcount & c_row_mask) == c_row_mask))
                            r_row_base <= r_row_base + c_fb_w;
                    end
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                    if (r_bar_px == c_bar_last) begin
                        r_bar_px  <= '0;
                        r_bar_idx <= r_bar_idx + 1'b1;
                    end else begin
                        r_bar_px <= r_bar_px + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_colour = 12'h000;
        if (r_s1_vis) begin
            case (r_mode)
                2'd0:    w_colour = r_pal[fb.fb_rd_data];
                2'd1:    w_colour = {{4{r_s1_bar[2]}}, {4{r_s1_bar[1]}}, {4{r_s1_bar[0]}}};
                default: w_colour = r_pal[0];
            endcase
        end
    end

    // Stage 1 issues the read, stage 2 consumes it; sync rides the same two
    // stages so pins stay aligned with colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb.fb_rd_en   <= 1'b0;
            fb.fb_rd_addr <= '0;
            r_s1_vis      <= 1'b0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_bar      <= '0;
            r_mode        <= 2'd0;
            hSync         <= 1'b1;
            vSync         <= 1'b1;
            VGA_R         <= 4'h0;
            VGA_G         <= 4'h0;
            VGA_B         <= 4'h0;
            active_out    <= 1'b0;
            frame_end     <= 1'b0;
        end else begin
            frame_end <= w_frame_tick;
            if (w_frame_tick)
                r_mode <= mode;
            if (w_pix_ce) begin
                fb.fb_rd_en <= w_visible && (r_mode == 2'd0);
                if (w_visible)
                    fb.fb_rd_addr <= w_addr;
                r_s1_vis <= w_visible;
                r_s1_hs  <= w_hs_n;
                r_s1_vs  <= w_vs_n;
                r_s1_bar <= r_bar_idx;
                {VGA_R, VGA_G, VGA_B} <= w_colour;
                hSync      <= r_s1_hs;
                vSync      <= r_s1_vs;
                active_out <= r_s1_vis;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPAL; i++)
                r_pal[i] <= (i == 0) ? 12'hFFF : 12'h000;
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vga_scaled_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scaled_display
// Brief    : Scoreboard bench for vga_scaled_display on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scaled_display;
    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 16;
    localparam int V_ACTIVE = 8;
    localparam int ADDR_W   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_addr = 2'd0;
    logic [11:0] pal_data = 12'h000;
    logic        hSync, vSync, active_out, frame_end;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    vga_scaled_display_if #(.PIX_BITS(2), .ADDR_W(ADDR_W)) fb_if ();

    vga_scaled_display #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(V_ACTIVE), .V_FP(1), .V_SYNC(2), .V_BP(1), .SCALE_SHIFT(1),
        .PIX_BITS(2), .RD_LATENCY(1), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .fb(fb_if), .hSync(hSync), .vSync(vSync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .active_out(active_out),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt;
    logic [11:0]       rgb_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    logic [11:0] bar_lut [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                                 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

    // Framebuffer contents: a fixed function of address, one clk read latency.
    function automatic logic [1:0] fbf(input logic [ADDR_W-1:0] a);
        return a[1:0] + a[3:2];
    endfunction

    always @(posedge clk) fb_if.fb_rd_data <= fbf(fb_if.fb_rd_addr);

    always @(posedge clk or negedge reset)
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (clk %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output with empty expectation queue (clk %0d)", name, ecnt);
    endtask

    // 8x4 framebuffer upscaled 2x into 16x8 visible pixels.
    task automatic push_frame(input logic [1:0] m, input logic [11:0] p0, p1, p2, p3);
        logic [11:0]       pal [4];
        logic [ADDR_W-1:0] a;
        pal[0] = p0; pal[1] = p1; pal[2] = p2; pal[3] = p3;
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++) begin
                a = ADDR_W'((y / 2) * 8 + x / 2);
                case (m)
                    2'd0: begin
                        rgb_q.push_back(pal[fbf(a)]);
                        addr_q.push_back(a);
                    end
                    2'd1:    rgb_q.push_back(bar_lut[x / 2]);
                    default: rgb_q.push_back(pal[0]);
                endcase
            end
        end
    endtask

    task automatic wait_e(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hsync"}, hSync, 1);
        check({tag, "_vsync"}, vSync, 1);
        check({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        check({tag, "_active"}, active_out, 0);
        check({tag, "_frame_end"}, frame_end, 0);
        check({tag, "_rd_en"}, fb_if.fb_rd_en, 0);
        check({tag, "_rd_addr"}, fb_if.fb_rd_addr, 0);
    endtask

    // Pixel monitor: pins change only just after every 4th edge since release.
    always @(negedge clk) begin
        if (reset && ecnt > 0 && (ecnt % CLK_DIV) == 0) begin
            if (active_out) begin
                if (rgb_q.size() == 0) flag("pixel");
                else check("pixel_rgb", {VGA_R, VGA_G, VGA_B}, rgb_q.pop_front());
            end else begin
                check("blank_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            end
            if (fb_if.fb_rd_en) begin
                if (addr_q.size() == 0) flag("fb_read");
                else check("fb_rd_addr", fb_if.fb_rd_addr, addr_q.pop_front());
            end
        end
    end

    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fe = 1'b0;
    int   hs_fall = -1, vs_fall = -1, fe_last = -1;

    always @(negedge clk) begin
        if (!reset) begin
            prev_hs = 1'b1; prev_vs = 1'b1; prev_fe = 1'b0;
            hs_fall = -1; vs_fall = -1; fe_last = -1;
        end else begin
            if (prev_hs && !hSync) begin
                check("hsync_phase", ecnt % 96, 80);
                if (hs_fall >= 0) check("hsync_period", ecnt - hs_fall, 96);
                hs_fall = ecnt;
            end
            if (!prev_hs && hSync && hs_fall >= 0) check("hsync_low", ecnt - hs_fall, 12);
            if (prev_vs && !vSync) begin
                check("vsync_phase", ecnt % 1152, 872);
                if (vs_fall >= 0) check("vsync_period", ecnt - vs_fall, 1152);
                vs_fall = ecnt;
            end
            if (!prev_vs && vSync && vs_fall >= 0) check("vsync_low", ecnt - vs_fall, 192);
            if (frame_end) begin
                check("frame_end_phase", ecnt % 1152, 768);
                check("frame_end_width", prev_fe, 0);
                check("last_fb_addr", fb_if.fb_rd_addr, 31);
                if (fe_last >= 0) check("frame_end_period", ecnt - fe_last, 1152);
                fe_last = ecnt;
            end
            prev_hs = hSync; prev_vs = vSync; prev_fe = frame_end;
        end
    end

    initial begin
        repeat (10) @(negedge clk);
        check_reset_outputs("reset");
        push_frame(2'd0, 12'hFFF, 12'h0F0, 12'hF00, 12'h00F);
        reset = 1'b1;
        pal_we = 1'b1; pal_addr = 2'd1; pal_data = 12'h0F0;
        @(negedge clk); pal_addr = 2'd2; pal_data = 12'hF00;
        @(negedge clk); pal_addr = 2'd3; pal_data = 12'h00F;
        @(negedge clk); pal_we = 1'b0;
        check("pre_ce_rd_en", fb_if.fb_rd_en, 0);
        @(negedge clk);
        check("first_ce_rd_en", fb_if.fb_rd_en, 1);
        check("first_ce_addr", fb_if.fb_rd_addr, 0);

        // Mid-frame mode changes only take effect on the following frame.
        wait_e(400);  mode = 2'd1; push_frame(2'd1, 12'hFFF, 12'h0F0, 12'hF00, 12'h00F);
        wait_e(1500); mode = 2'd2; push_frame(2'd2, 12'hFFF, 12'h0F0, 12'hF00, 12'h00F);
        wait_e(2400); mode = 2'd3;
        wait_e(3200);
        pal_we = 1'b1; pal_addr = 2'd0; pal_data = 12'h0A5;
        push_frame(2'd3, 12'h0A5, 12'h0F0, 12'hF00, 12'h00F);
        @(negedge clk); pal_we = 1'b0;

        // Reset in the middle of a visible line of the fourth frame.
        wait_e(3690);
        reset = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        rgb_q.delete();
        addr_q.delete();
        repeat (10) @(negedge clk);
        check_reset_outputs("held_reset");
        mode = 2'd0;
        push_frame(2'd0, 12'hFFF, 12'h000, 12'h000, 12'h000);
        push_frame(2'd0, 12'hFFF, 12'h000, 12'h000, 12'h000);
        reset = 1'b1;
        wait_e(2100);
        check("pixels_drained", rgb_q.size(), 0);
        check("reads_drained", addr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
